// File: rtl/timer_unit_pkg.sv
// timer_unit_pkg: SFR op bits, timer mode encodings and channel-select width helper.
package timer_unit_pkg;
  localparam int SFR_OP_LEN = 8;
  typedef logic [SFR_OP_LEN-1:0] sfr_op_t;
  localparam sfr_op_t OP_TMR_WR_MODE = 8'h01;
  localparam sfr_op_t OP_TMR_WR_TL   = 8'h02;
  localparam sfr_op_t OP_TMR_WR_TH   = 8'h04;
  localparam sfr_op_t OP_TMR_WR_RUN  = 8'h08;
  localparam sfr_op_t OP_TMR_CLR_TF  = 8'h10;
  typedef enum logic [1:0] {
    TMR_MODE_13   = 2'b00,
    TMR_MODE_16   = 2'b01,
    TMR_MODE_AR8  = 2'b10,
    TMR_MODE_HALT = 2'b11
  } tmr_mode_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/timer_unit_if.sv
// timer_unit_if: SFR write bus (op mask, channel select, data byte); master drives, slave receives.
interface timer_unit_if import timer_unit_pkg::*; #(parameter int CH_W = 1);
  sfr_op_t         i_op;
  logic [CH_W-1:0] i_sel;
  logic [7:0]      i_byte;
  modport master (output i_op, i_sel, i_byte);
  modport slave  (input  i_op, i_sel, i_byte);
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one 8051-style timer channel (pin synchronisers, mode counter, TL/TH, run, TF).
// Ports: decoded per-channel write strobes + data byte, shared prescaler tick, async pins, tf ack;
// outputs are the mode nibble, TL, TH, run and TF registers.
module timer_channel import timer_unit_pkg::*; (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_t_pin,
  input  logic       i_int_pin,
  input  logic       i_wr_mode,
  input  logic       i_wr_tl,
  input  logic       i_wr_th,
  input  logic       i_wr_run,
  input  logic       i_clr_tf,
  input  logic       i_tf_ack,
  input  logic [7:0] i_byte,
  output logic [3:0] o_mode,
  output logic [7:0] o_tl,
  output logic [7:0] o_th,
  output logic       o_run,
  output logic       o_tf
);
  logic [1:0] t_sync_q, int_sync_q;
  logic       t_prev_q, run_q, run_d, tf_q, tf_d, tk, adv, ovf;
  logic [3:0] mode_q, mode_d;
  logic [7:0] tl_q, tl_d, th_q, th_d, tl_t, th_t;
  tmr_mode_e  m;
  always_comb begin
    m = tmr_mode_e'(mode_q[1:0]);
    tk = run_q & (~mode_q[3] | int_sync_q[1]) & (mode_q[2] ? (t_prev_q & ~t_sync_q[1]) : i_tick);
    tl_t = tl_q;
    th_t = th_q;
    ovf = 1'b0;
    unique case (m)
      TMR_MODE_13: begin
        tl_t = {tl_q[7:5], tl_q[4:0] + 5'd1};
        th_t = th_q + {7'd0, &tl_q[4:0]};
        ovf = (&th_q) & (&tl_q[4:0]);
      end
      TMR_MODE_16: begin
        {th_t, tl_t} = {th_q, tl_q} + 16'd1;
        ovf = &{th_q, tl_q};
      end
      TMR_MODE_AR8: begin
        tl_t = (&tl_q) ? th_q : tl_q + 8'd1;
        ovf = &tl_q;
      end
      default: ;
    endcase
    // a CPU write to either byte swallows the tick for both bytes, including its overflow
    adv = tk & ~(i_wr_tl | i_wr_th);
    tl_d = i_wr_tl ? i_byte : (adv ? tl_t : tl_q);
    th_d = i_wr_th ? i_byte : (adv ? th_t : th_q);
    mode_d = i_wr_mode ? i_byte[3:0] : mode_q;
    run_d = i_wr_run ? i_byte[0] : run_q;
    tf_d = (adv & ovf) | (tf_q & ~(i_clr_tf | i_tf_ack));
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_sync_q <= '0;
      int_sync_q <= '0;
      t_prev_q <= 1'b0;
      mode_q <= '0;
      tl_q <= '0;
      th_q <= '0;
      run_q <= 1'b0;
      tf_q <= 1'b0;
    end else begin
      t_sync_q <= {t_sync_q[0], i_t_pin};
      int_sync_q <= {int_sync_q[0], i_int_pin};
      t_prev_q <= t_sync_q[1];
      mode_q <= mode_d;
      tl_q <= tl_d;
      th_q <= th_d;
      run_q <= run_d;
      tf_q <= tf_d;
    end
  end
  assign o_mode = mode_q;
  assign o_tl = tl_q;
  assign o_th = th_q;
  assign o_run = run_q;
  assign o_tf = tf_q;
endmodule

// File: rtl/timer_unit.sv
// timer_unit: N_TIMERS 8051 timer channels behind the SFR write bus with a shared free-running prescaler.
// Ports: i_clk/i_rst, bus (op/sel/byte), per-channel t/int pins and tf acks; packed mode/TL/TH/run/TF outputs.
module timer_unit import timer_unit_pkg::*; #(
  parameter int N_TIMERS = 2,
  parameter int PRESCALE = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  timer_unit_if.slave           bus,
  input  logic [N_TIMERS-1:0]   i_t_pin,
  input  logic [N_TIMERS-1:0]   i_int_pin,
  input  logic [N_TIMERS-1:0]   i_tf_ack,
  output logic [4*N_TIMERS-1:0] o_mode,
  output logic [8*N_TIMERS-1:0] o_tl,
  output logic [8*N_TIMERS-1:0] o_th,
  output logic [N_TIMERS-1:0]   o_run,
  output logic [N_TIMERS-1:0]   o_tf
);
  localparam int CH_W = ch_w(N_TIMERS);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  always_comb begin
    tick = pre_q == PW'(PRESCALE - 1);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pre_q <= '0;
    else pre_q <= pre_d;
  end
  for (genvar k = 0; k < N_TIMERS; k++) begin : g_ch
    logic hit;
    // selects beyond the last channel match no instance and are dropped
    assign hit = bus.i_sel == CH_W'(k);
    timer_channel u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (tick),
      .i_t_pin   (i_t_pin[k]),
      .i_int_pin (i_int_pin[k]),
      .i_wr_mode (hit & |(bus.i_op & OP_TMR_WR_MODE)),
      .i_wr_tl   (hit & |(bus.i_op & OP_TMR_WR_TL)),
      .i_wr_th   (hit & |(bus.i_op & OP_TMR_WR_TH)),
      .i_wr_run  (hit & |(bus.i_op & OP_TMR_WR_RUN)),
      .i_clr_tf  (hit & |(bus.i_op & OP_TMR_CLR_TF)),
      .i_tf_ack  (i_tf_ack[k]),
      .i_byte    (bus.i_byte),
      .o_mode    (o_mode[4*k +: 4]),
      .o_tl      (o_tl[8*k +: 8]),
      .o_th      (o_th[8*k +: 8]),
      .o_run     (o_run[k]),
      .o_tf      (o_tf[k])
    );
  end
endmodule
